// File: rtl/ipf_pkg.sv
// Shared IPF constants and elaboration-time parameter checks.
package ipf_pkg;

    localparam int IPF_RES_W   = 9216;
    localparam int IPF_SLICE_W = 64;

    function automatic bit ipf_slice_ok(input int res_w, input int slice_w);
        return (slice_w > 0) && (res_w >= slice_w) && (res_w % slice_w == 0);
    endfunction

    function automatic bit ipf_pow2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/ipf_result_buf_ctrl.sv
// Pointer, occupancy, beat and overflow bookkeeping for the result buffer.
module ipf_result_buf_ctrl #(
    parameter  int DEPTH = 4,
    parameter  int BEATS = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1,
    localparam int BW    = $clog2(BEATS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          res_valid,
    input  logic          out_ready,
    output logic          wr_en,
    output logic [PW-1:0] wr_ptr,
    output logic [PW-1:0] rd_ptr,
    output logic          out_valid,
    output logic          out_last,
    output logic [BW-1:0] out_beat,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          ovf
);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [BW-1:0] beat_q, beat_d;
    logic          full_q, full_d;
    logic          ovf_q, ovf_d;

    logic xfer, last_beat, pop, wr, drop;

    assign out_valid = (count_q != '0);
    assign last_beat = (beat_q == BW'(BEATS - 1));
    assign xfer      = out_valid && out_ready;
    assign pop       = xfer && last_beat;
    // A pop in the same cycle frees a slot, so a full buffer can still accept.
    assign wr        = res_valid && (!full_q || pop);
    assign drop      = res_valid && full_q && !pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        beat_d   = beat_q;
        ovf_d    = ovf_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            beat_d   = '0;
            ovf_d    = 1'b0;
        end else begin
            if (wr)
                wr_ptr_d = wr_ptr_q + 1'b1;
            if (xfer)
                beat_d = last_beat ? '0 : beat_q + 1'b1;
            if (pop)
                rd_ptr_d = rd_ptr_q + 1'b1;
            if (drop)
                ovf_d = 1'b1;
            unique case ({wr, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
        full_d = (count_d == CW'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            beat_q   <= '0;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            beat_q   <= beat_d;
            full_q   <= full_d;
            ovf_q    <= ovf_d;
        end
    end

    assign wr_en    = wr && !clear && !rst;
    assign wr_ptr   = wr_ptr_q;
    assign rd_ptr   = rd_ptr_q;
    assign out_last = out_valid && last_beat;
    assign out_beat = beat_q;
    assign count    = count_q;
    assign full     = full_q;
    assign ovf      = ovf_q;

endmodule

// File: rtl/ipf_result_buf.sv
// Captures IPF result vectors into a circular buffer and drains each one
// as SLICE_W-bit beats, LSB slice first, over a valid/ready handshake.
module ipf_result_buf
    import ipf_pkg::*;
#(
    parameter  int RES_W   = IPF_RES_W,
    parameter  int SLICE_W = IPF_SLICE_W,
    parameter  int DEPTH   = 4,
    localparam int BEATS   = RES_W / SLICE_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       res_valid,
    input  logic [RES_W-1:0]           result,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [SLICE_W-1:0]         out_data,
    output logic                       out_last,
    output logic [$clog2(BEATS)-1:0]   out_beat,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       ovf
);

    localparam int PW = $clog2(DEPTH);

    if (!ipf_slice_ok(RES_W, SLICE_W)) begin : g_bad_slice
        $error("ipf_result_buf: RES_W must be a multiple of SLICE_W");
    end
    if (!ipf_pow2(DEPTH)) begin : g_bad_depth
        $error("ipf_result_buf: DEPTH must be a power of two >= 2");
    end

    logic          wr_en;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    ipf_result_buf_ctrl #(
        .DEPTH (DEPTH),
        .BEATS (BEATS)
    ) u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .res_valid (res_valid),
        .out_ready (out_ready),
        .wr_en     (wr_en),
        .wr_ptr    (wr_ptr),
        .rd_ptr    (rd_ptr),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_beat  (out_beat),
        .count     (count),
        .full      (full),
        .ovf       (ovf)
    );

    // Storage is deliberately not reset; occupancy alone says what is valid.
    logic [RES_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem_q[wr_ptr] <= result;
    end

    logic [BEATS-1:0][SLICE_W-1:0] rd_slices;

    assign rd_slices = mem_q[rd_ptr];
    assign out_data  = out_valid ? rd_slices[out_beat] : '0;

endmodule

// File: tb/tb_ipf_result_buf.sv
// Bench for ipf_result_buf: per-cycle queue model plus table and directed corners.
module tb_ipf_result_buf;

    localparam int RES_W = 256;
    localparam int SW    = 64;
    localparam int DEPTH = 4;
    localparam int BEATS = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             clear = 1'b0;
    logic             res_valid = 1'b0;
    logic [RES_W-1:0] result = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [SW-1:0]    out_data;
    logic             out_last;
    logic [1:0]       out_beat;
    logic [2:0]       count;
    logic             full;
    logic             ovf;

    ipf_result_buf #(.RES_W(RES_W), .SLICE_W(SW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .res_valid (res_valid),
        .result    (result),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_beat  (out_beat),
        .count     (count),
        .full      (full),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [RES_W-1:0] act, input logic [RES_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [RES_W-1:0] mk(input logic [31:0] k);
        return {k, 32'h3, k, 32'h2, k, 32'h1, k, 32'h0};
    endfunction

    // Behavioural model: a queue of pending beats plus occupancy/ovf state.
    logic [SW-1:0] q[$];
    int            m_count = 0;
    int            m_beat  = 0;
    bit            m_ovf   = 0;
    bit            started = 0;
    int            delivered = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                chk("count", RES_W'(count), RES_W'(m_count));
                chk("full", RES_W'(full), RES_W'(m_count == DEPTH));
                chk("ovf", RES_W'(ovf), RES_W'(m_ovf));
                chk("out_valid", RES_W'(out_valid), RES_W'(m_count != 0));
                if (m_count != 0 && q.size() != 0) begin
                    chk("out_data", RES_W'(out_data), RES_W'(q[0]));
                    chk("out_beat", RES_W'(out_beat), RES_W'(m_beat));
                    chk("out_last", RES_W'(out_last), RES_W'(m_beat == BEATS - 1));
                end else begin
                    chk("idle_data", RES_W'(out_data), '0);
                    chk("idle_last", RES_W'(out_last), '0);
                end
            end
            if (rst || clear) begin
                m_count = 0;
                m_beat  = 0;
                m_ovf   = 0;
                q.delete();
                if (rst) started = 1;
            end else begin
                bit xfer, pop, wr;
                xfer = (m_count != 0) && out_ready;
                pop  = xfer && (m_beat == BEATS - 1);
                wr   = res_valid && ((m_count < DEPTH) || pop);
                if (res_valid && !wr) m_ovf = 1;
                if (xfer) begin
                    if (q.size() != 0) void'(q.pop_front());
                    m_beat = pop ? 0 : m_beat + 1;
                    delivered++;
                end
                if (wr)
                    for (int s = 0; s < BEATS; s++) q.push_back(result[s*SW +: SW]);
                m_count = m_count + int'(wr) - int'(pop);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; clear = 1'b0; res_valid = 1'b0; out_ready = 1'b0;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic drain(input int lim, input string name);
        out_ready = 1'b1;
        for (int i = 0; i < lim; i++) begin
            if (m_count == 0) return;
            step();
        end
        chk({name, "_drain_timeout"}, RES_W'(m_count), '0);
    endtask

    typedef struct {
        bit               rv;
        logic [RES_W-1:0] d;
        bit               rdy;
        int               cnt;
        bit               fl;
        bit               of;
    } vec_t;

    initial begin
        vec_t             vt[5];
        logic [RES_W-1:0] t;
        bit               found;

        // Reset state.
        do_reset();
        chk("rst_valid", RES_W'(out_valid), '0);
        chk("rst_last", RES_W'(out_last), '0);
        chk("rst_beat", RES_W'(out_beat), '0);
        chk("rst_data", RES_W'(out_data), '0);
        chk("rst_count", RES_W'(count), '0);
        chk("rst_full", RES_W'(full), '0);
        chk("rst_ovf", RES_W'(ovf), '0);

        // Single entry, consecutive beats.
        t = {{16{4'h3}}, {16{4'h2}}, {16{4'h1}}, {16{4'h0}}};
        out_ready = 1'b1; res_valid = 1'b1; result = t;
        step();
        res_valid = 1'b0;
        for (int b = 0; b < BEATS; b++) begin
            chk("se_beat", RES_W'(out_beat), RES_W'(b));
            chk("se_data", RES_W'(out_data), RES_W'(t[b*SW +: SW]));
            chk("se_last", RES_W'(out_last), RES_W'(b == BEATS - 1));
            chk("se_count1", RES_W'(count), RES_W'(1));
            step();
        end
        chk("se_count0", RES_W'(count), '0);
        chk("se_valid0", RES_W'(out_valid), '0);

        // Backpressure 1,0,0,1,...
        do_reset();
        delivered = 0;
        res_valid = 1'b1; result = mk(32'h77);
        step();
        res_valid = 1'b0;
        for (int i = 0; i < 40 && m_count != 0; i++) begin
            out_ready = (i % 4 == 0) || (i % 4 == 3);
            step();
        end
        chk("bp_done", RES_W'(m_count), '0);
        chk("bp_delivered", RES_W'(delivered), RES_W'(BEATS));

        // Fill and overflow, hand-derived table.
        do_reset();
        vt[0] = '{1, mk(32'hA), 0, 1, 0, 0};
        vt[1] = '{1, mk(32'hB), 0, 2, 0, 0};
        vt[2] = '{1, mk(32'hC), 0, 3, 0, 0};
        vt[3] = '{1, mk(32'hD), 0, 4, 1, 0};
        vt[4] = '{1, mk(32'hE), 0, 4, 1, 1};
        foreach (vt[i]) begin
            res_valid = vt[i].rv; result = vt[i].d; out_ready = vt[i].rdy;
            step();
            chk("tbl_count", RES_W'(count), RES_W'(vt[i].cnt));
            chk("tbl_full", RES_W'(full), RES_W'(vt[i].fl));
            chk("tbl_ovf", RES_W'(ovf), RES_W'(vt[i].of));
        end
        res_valid = 1'b0;
        t = mk(32'hA);
        chk("ovf_head", RES_W'(out_data), RES_W'(t[SW-1:0]));
        drain(40, "ovf");
        chk("ovf_sticky", RES_W'(ovf), RES_W'(1));

        // Write coinciding with pop on a full buffer.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            res_valid = 1'b1; result = mk(32'h10 + i);
            step();
        end
        res_valid = 1'b0; out_ready = 1'b1;
        found = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid && out_last) begin found = 1; break; end
            step();
        end
        chk("cp_found_last", RES_W'(found), RES_W'(1));
        res_valid = 1'b1; result = mk(32'hF);
        step();
        res_valid = 1'b0;
        chk("cp_count", RES_W'(count), RES_W'(4));
        chk("cp_full", RES_W'(full), RES_W'(1));
        chk("cp_ovf", RES_W'(ovf), '0);
        drain(60, "cp");

        // Wrap-around: 10 entries interleaved with draining.
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            res_valid = 1'b1; result = mk(32'h100 + i) ^ {$urandom, 224'h0};
            step();
            res_valid = 1'b0;
            for (int j = 0; j < 3; j++) step();
        end
        drain(40, "wrap");
        chk("wrap_ovf", RES_W'(ovf), '0);

        // Clear mid-drain, with a write in the clear cycle.
        do_reset();
        for (int i = 0; i < 2; i++) begin
            res_valid = 1'b1; result = mk(32'h200 + i);
            step();
        end
        res_valid = 1'b0; out_ready = 1'b1;
        found = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_beat == 2'd2) begin found = 1; break; end
            step();
        end
        chk("clr_found_beat2", RES_W'(found), RES_W'(1));
        clear = 1'b1; res_valid = 1'b1; result = mk(32'h299);
        step();
        clear = 1'b0; res_valid = 1'b0;
        chk("clr_valid", RES_W'(out_valid), '0);
        chk("clr_count", RES_W'(count), '0);
        chk("clr_ovf", RES_W'(ovf), '0);
        t = mk(32'h300);
        res_valid = 1'b1; result = t;
        step();
        res_valid = 1'b0;
        chk("clr_beat0", RES_W'(out_beat), '0);
        chk("clr_data0", RES_W'(out_data), RES_W'(t[SW-1:0]));
        drain(20, "clr");

        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ipf_result_buf.md
# ipf_result_buf

Parametrised result capture and drain buffer for the IPF convolution engine. It sits directly after IPF's `result`/`res_valid` output. It stores up to DEPTH full-width result vectors in a circular buffer, then streams each one out as SLICE_W-bit beats over a valid/ready handshake, LSB slice first. It adds backpressure, occupancy reporting, overflow detection and a soft clear.

## Interface
- RES_W, 9216: width of one IPF result vector; must be an integer multiple of SLICE_W.
- SLICE_W, 64: output beat width.
- DEPTH, 4: number of result entries stored; power of two, ≥2.
- BEATS (localparam): RES_W/SLICE_W; defaults give 144.

Ports:
- clk  in  1  clock; everything is sampled on the rising edge.
- rst  in  1  synchronous reset, active-high.
- clear  in  1  synchronous soft flush; same effect as rst on state.
- res_valid  in  1  result present this cycle.
- result  in  RES_W  result vector from IPF.
- out_valid  out  1  beat available.
- out_ready  in  1  consumer accepts beat.
- out_data  out  SLICE_W  current beat.
- out_last  out  1  current beat is the final beat (BEATS-1) of its entry.
- out_beat  out  $clog2(BEATS)  index of the current beat within its entry.
- count  out  $clog2(DEPTH)+1  number of stored entries, including a partially drained entry.
- full  out  1  count==DEPTH.
- ovf  out  1  sticky: a result was dropped.

## Operation
- Storage is an array of DEPTH registers of RES_W bits, with wr_ptr and rd_ptr of $clog2(DEPTH) bits each. Both pointers wrap modulo DEPTH.
- **Write:** a write occurs when res_valid=1. If the buffer is not full, or if a pop completes in the same cycle:
  - mem[wr_ptr]<=result;
  - wr_ptr++.
- **Drop:** if res_valid=1, full=1 and no pop completes in that cycle, the result is dropped and ovf is set to 1. Stored data and pointers are unchanged.
- **Drain:**
  - out_valid = (count!=0).
  - out_data = mem[rd_ptr][out_beat*SLICE_W +: SLICE_W] when out_valid=1; otherwise out_data = 0.
  - A beat transfers when out_valid && out_ready. On transfer, out_beat increments.
  - On transfer of the beat with out_beat==BEATS-1 (a "pop"): out_beat<=0, rd_ptr++, and the entry is freed.
- **Count:**
  - +1 on a write without a pop.
  - −1 on a pop without a write.
  - Unchanged when both occur, or neither.
- **Overflow flag:** ovf is cleared only by rst or clear.
- **Reset/clear:** the following are reset: wr_ptr=0, rd_ptr=0, count=0, out_beat=0, ovf=0. Memory contents are not reset.
- **Clear priority:** clear overrides a simultaneous write or transfer. The result presented in that cycle is discarded and ovf is not set.
- **Mid-drain reset/clear:** asserting rst or clear in the middle of a drain abandons the partial entry. No further beats of that entry are emitted.
- **Consumer rule:** out_ready is allowed to toggle on any cycle. out_data and out_beat must hold stable while out_valid=1 and out_ready=0.

## Timing
- Reset values:
  - out_valid=0, out_last=0, out_beat=0, out_data=0;
  - count=0, full=0, ovf=0.
- Write-to-output latency: res_valid at edge N into an empty buffer gives out_valid=1 and beat 0 of that entry after edge N (cycle N+1).
- Throughput is one beat per cycle with out_ready held at 1. One entry drains in BEATS cycles.
- Back-to-back entries drain with no bubble: beat 0 of the next entry follows the last beat of the previous entry on the next cycle.
- Flag timing:
  - full and count are registered and update on the same edge as the write or pop.
  - ovf rises on the edge following the dropped res_valid.
- Full-buffer case: with full=1, a res_valid that coincides with a pop is accepted. count stays at DEPTH and ovf stays 0.

## Structure
- Shared package `ipf_pkg`:
  - IPF_RES_W=9216, IPF_SLICE_W=64;
  - the rule RES_W % SLICE_W == 0, checked by an elaboration-time assertion.
- Sub-module `ipf_result_buf_ctrl`:
  - contains the pointers, count, out_beat counter, full and ovf logic;
  - has no data path.
- The top level holds the memory array and the output slice mux.

## Test plan
Bench parameters for all scenarios: RES_W=256, SLICE_W=64, DEPTH=4, so BEATS=4.
- Single entry: reset, then one res_valid with result=256'h3333…_2222…_1111…_0000… (64-bit slices), out_ready=1.
  - Required: beats 0..3 are 0000…, 1111…, 2222…, 3333… on consecutive cycles.
  - out_last is 1 on beat 3 only; count goes 1→0.
- Backpressure: out_ready toggles 1,0,0,1,…
  - Required: out_data and out_beat hold stable while stalled.
  - All 4 beats are delivered in order with no duplicates.
- Fill and overflow: out_ready=0, then 5 consecutive res_valid with values A..E.
  - Required: count=4 and full=1, ovf=1 after the fifth write.
  - Draining gives A, B, C, D only.
- Write coinciding with pop: buffer full, out_ready=1, res_valid pulsed on the cycle that out_last transfers.
  - Required: the new entry is accepted, count stays 4 and ovf stays 0.
- Wrap-around: 10 entries written and drained interleaved.
  - Required: the output order matches the input order across pointer wrap.
- Clear mid-drain: clear asserted at beat 2 of entry 0 while 2 entries are stored.
  - Required: the next cycle has out_valid=0, count=0, ovf=0.
  - A subsequent write drains from beat 0.
